gamepad_reader: RTL and testbench

- Drives the serial SNES-style controller port and deserialises the 16-bit button word.
- Produces the registered button levels consumed by player logic: A, B, select, start, up, down, left, right.
- Sits between the board controller pins and the game-state modules.
- One read is performed per poll strobe, issued once per frame by the top level.

---
 rtl/gamepad_reader_if.sv | 30 +++
 rtl/gamepad_reader.sv | 131 +++++++++++++
 tb/tb_gamepad_reader.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/gamepad_reader_if.sv
// rtl/gamepad_reader_if.sv - controller pins, poll handshake and decoded buttons of the gamepad reader
interface gamepad_reader_if;
    logic poll;
    logic pad_data;
    logic pad_latch;
    logic pad_clk;
    logic busy;
    logic valid;
    logic pad_present;
    logic A;
    logic B;
    logic select;
    logic start;
    logic up;
    logic down;
    logic left;
    logic right;

    modport master (
        input  poll, pad_data,
        output pad_latch, pad_clk, busy, valid, pad_present,
        output A, B, select, start, up, down, left, right
    );

    modport slave (
        output poll, pad_data,
        input  pad_latch, pad_clk, busy, valid, pad_present,
        input  A, B, select, start, up, down, left, right
    );
endinterface

// File: rtl/gamepad_reader.sv
// rtl/gamepad_reader.sv - SNES-style serial pad reader producing registered, SOCD-cleaned button levels
module gamepad_reader #(
    parameter int HALF_CYCLES  = 150,
    parameter int LATCH_CYCLES = 300
) (
    input  logic          clk,
    input  logic          rst,
    gamepad_reader_if.master pad
);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] LATCH    = 3'd1;
    localparam logic [2:0] BIT_HIGH = 3'd2;
    localparam logic [2:0] BIT_LOW  = 3'd3;
    localparam logic [2:0] DONE     = 3'd4;

    localparam int CMAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
    localparam int CW   = $clog2(CMAX) + 1;
    localparam logic [CW-1:0] LATCH_LAST = CW'(LATCH_CYCLES - 1);
    localparam logic [CW-1:0] HALF_LAST  = CW'(HALF_CYCLES - 1);

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [3:0]    idx;
    logic [15:0]   shift_reg;
    logic          data_meta;
    logic          data_sync;

    logic [15:0] pressed;
    logic        present_w;
    logic        ud_ok;
    logic        lr_ok;

    // Line is active-low; a pad always drives bits 12-15 high, a pull-down reads them low.
    assign pressed   = ~shift_reg;
    assign present_w = &shift_reg[15:12];
    assign ud_ok     = !(pressed[4] && pressed[5]);
    assign lr_ok     = !(pressed[6] && pressed[7]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_meta <= 1'b0;
            data_sync <= 1'b0;
        end else begin
            data_meta <= pad.pad_data;
            data_sync <= data_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            idx             <= '0;
            shift_reg       <= '0;
            pad.pad_latch   <= 1'b0;
            pad.pad_clk     <= 1'b1;
            pad.busy        <= 1'b0;
            pad.valid       <= 1'b0;
            pad.pad_present <= 1'b0;
            pad.A           <= 1'b0;
            pad.B           <= 1'b0;
            pad.select      <= 1'b0;
            pad.start       <= 1'b0;
            pad.up          <= 1'b0;
            pad.down        <= 1'b0;
            pad.left        <= 1'b0;
            pad.right       <= 1'b0;
        end else begin
            pad.valid <= 1'b0;
            case (state)
                IDLE: begin
                    // busy is still high during the valid cycle, so a poll there is dropped too.
                    if (pad.busy) begin
                        pad.busy <= 1'b0;
                    end else if (pad.poll) begin
                        state         <= LATCH;
                        cnt           <= '0;
                        pad.busy      <= 1'b1;
                        pad.pad_latch <= 1'b1;
                    end
                end
                LATCH: begin
                    if (cnt == LATCH_LAST) begin
                        cnt           <= '0;
                        idx           <= '0;
                        pad.pad_latch <= 1'b0;
                        state         <= BIT_HIGH;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BIT_HIGH: begin
                    if (cnt == HALF_LAST) begin
                        cnt            <= '0;
                        shift_reg[idx] <= data_sync;
                        pad.pad_clk    <= 1'b0;
                        state          <= BIT_LOW;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BIT_LOW: begin
                    if (cnt == HALF_LAST) begin
                        cnt         <= '0;
                        pad.pad_clk <= 1'b1;
                        idx         <= idx + 1'b1;
                        state       <= (idx == 4'd15) ? DONE : BIT_HIGH;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    pad.valid       <= 1'b1;
                    pad.pad_present <= present_w;
                    pad.A           <= present_w & pressed[8];
                    pad.B           <= present_w & pressed[0];
                    pad.select      <= present_w & pressed[2];
                    pad.start       <= present_w & pressed[3];
                    pad.up          <= present_w & pressed[4] & ud_ok;
                    pad.down        <= present_w & pressed[5] & ud_ok;
                    pad.left        <= present_w & pressed[6] & lr_ok;
                    pad.right       <= present_w & pressed[7] & lr_ok;
                    state           <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_gamepad_reader.sv
// tb/tb_gamepad_reader.sv - scoreboard bench for gamepad_reader with a behavioural shift-register pad
module tb_gamepad_reader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    gamepad_reader_if pif();

    gamepad_reader #(.HALF_CYCLES(4), .LATCH_CYCLES(8)) dut (
        .clk (clk),
        .rst (rst),
        .pad (pif.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] exp;
        int         t0;
    } sb_t;
    sb_t sb_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_valid = 0;
    int n_latch = 0;

    logic [15:0] pad_word = 16'h0000;
    logic [15:0] sh = 16'h0000;

    // Pad model: parallel load on latch, next bit presented on each rising pad_clk.
    always @(posedge pif.pad_latch) sh = pad_word;
    always @(posedge pif.pad_clk) if (!pif.pad_latch) sh = {1'b0, sh[15:1]};
    assign pif.pad_data = sh[0];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] ref_out(input logic [15:0] w);
        logic [15:0] p;
        logic up_b, down_b, left_b, right_b;
        p = ~w;
        if (w[15:12] != 4'hF) return 9'd0;
        up_b    = p[4] && !p[5];
        down_b  = p[5] && !p[4];
        left_b  = p[6] && !p[7];
        right_b = p[7] && !p[6];
        return {1'b1, p[8], p[0], p[2], p[3], up_b, down_b, left_b, right_b};
    endfunction

    function automatic logic [8:0] dut_out();
        return {pif.pad_present, pif.A, pif.B, pif.select, pif.start,
                pif.up, pif.down, pif.left, pif.right};
    endfunction

    int  latch_run = 0;
    int  lo_run    = 0;
    int  hi_run    = 0;
    int  lows      = 0;
    bit  chk_busy  = 0;

    always @(negedge clk) begin
        if (rst) begin
            latch_run = 0;
            lo_run    = 0;
            hi_run    = 0;
            lows      = 0;
            chk_busy  = 0;
        end else begin
            if (chk_busy) begin
                check("busy_after_valid", pif.busy, 0);
                chk_busy = 0;
            end
            if (pif.pad_latch) begin
                latch_run++;
            end else if (latch_run != 0) begin
                check("latch_len", latch_run, 8);
                latch_run = 0;
                n_latch++;
            end
            if (!pif.pad_clk) begin
                if (lo_run == 0 && lows != 0) check("clk_high_len", hi_run, 4);
                lo_run++;
            end else begin
                if (lo_run != 0) begin
                    check("clk_low_len", lo_run, 4);
                    lows++;
                    lo_run = 0;
                    hi_run = 0;
                end
                hi_run++;
            end
            if (pif.valid) begin
                n_valid++;
                check("clk_low_pulses", lows, 16);
                lows = 0;
                check("sb_nonempty", sb_q.size() != 0, 1);
                if (sb_q.size() != 0) begin
                    sb_t e;
                    e = sb_q.pop_front();
                    check("buttons", dut_out(), e.exp);
                    check("valid_time", cyc - e.t0, 137);
                end
                chk_busy = 1;
            end
        end
    end

    task automatic pulse_poll(output int t0);
        @(negedge clk) pif.poll = 1'b1;
        @(negedge clk) pif.poll = 1'b0;
        t0 = cyc;
    endtask

    task automatic do_read(input logic [15:0] w);
        int t0;
        pad_word = w;
        pulse_poll(t0);
        sb_q.push_back('{exp: ref_out(w), t0: t0});
        for (int i = 0; i < 300 && sb_q.size() != 0; i++) @(negedge clk);
        check("read_done", sb_q.size(), 0);
        sb_q.delete();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int nv;
        int nl;
        pif.poll = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_latch", pif.pad_latch, 0);
        check("rst_clk", pif.pad_clk, 1);
        check("rst_busy", pif.busy, 0);
        check("rst_valid", pif.valid, 0);
        check("rst_outs", dut_out(), 9'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("idle_busy", pif.busy, 0);
        check("idle_latch", pif.pad_latch, 0);
        check("idle_no_valid", n_valid, 0);

        do_read(16'hFEFE);
        check("ab_A", pif.A, 1);
        check("ab_B", pif.B, 1);

        // Reset in the middle of a read, with buttons currently set.
        pad_word = 16'hFFFF;
        pulse_poll(t0);
        for (int i = 0; i < 100 && pif.pad_clk; i++) @(negedge clk);
        check("reached_bit_low", pif.pad_clk, 0);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_latch", pif.pad_latch, 0);
        check("mid_rst_clk", pif.pad_clk, 1);
        check("mid_rst_busy", pif.busy, 0);
        check("mid_rst_outs", dut_out(), 9'd0);
        nv = n_valid;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        check("post_rst_busy", pif.busy, 0);
        check("post_rst_no_valid", n_valid, nv);

        do_read(16'h0000);
        do_read(16'hFF4F);
        check("socd_up", pif.up, 0);
        check("socd_down", pif.down, 0);
        check("socd_right", pif.right, 1);
        do_read(16'hFF3F);
        do_read(16'hEFFF);
        for (int k = 0; k < 4; k++) do_read({4'hF, 12'($urandom)});

        // A second poll while busy must neither queue nor restart a read.
        nv = n_valid;
        nl = n_latch;
        pad_word = 16'hFF7E;
        pulse_poll(t0);
        sb_q.push_back('{exp: ref_out(16'hFF7E), t0: t0});
        repeat (49) @(negedge clk);
        pif.poll = 1'b1;
        @(negedge clk) pif.poll = 1'b0;
        for (int i = 0; i < 300 && sb_q.size() != 0; i++) @(negedge clk);
        check("ign_read_done", sb_q.size(), 0);
        repeat (200) @(negedge clk);
        check("ign_one_valid", n_valid, nv + 1);
        check("ign_one_latch", n_latch, nl + 1);
        check("ign_idle", pif.busy, 0);

        do_read(16'hFFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
